// File: rtl/spi_reg_if_if.sv
// Bus bundle between an SPI host and the register-write bridge: the three SPI
// pins plus the register-bank write port (we/addr/data_out) and the address-error pulse.
interface spi_reg_if_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  // Write port: we is a one-cycle strobe with no back-pressure. addr/data_out are
  // valid while we=1 and hold their last committed value otherwise.
  logic       we;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       addr_err;

  modport master (
    output sclk, cs_n, mosi,
    input  we, addr, data_out, addr_err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output we, addr, data_out, addr_err
  );
endinterface

// File: rtl/spi_reg_if.sv
// SPI mode-0 slave that turns 16-bit {addr, data} frames into single-cycle register
// writes. All SPI pins are oversampled in the clk domain through synchronizers.
module spi_reg_if #(
  parameter int NUM_REGS    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_if_if.slave    bus,
  output logic [1:0]     dbg_state
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int WW = $clog2(SS + 1);
  localparam logic [8:0]    NUM_REGS_L = (NUM_REGS > 256) ? 9'd256 : 9'(NUM_REGS);
  localparam logic [WW-1:0] WARM_MAX   = WW'(SS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ADDR    = 2'd1;
  localparam logic [1:0] DATA    = 2'd2;
  localparam logic [1:0] WAIT_CS = 2'd3;

  logic [SS-1:0] sclk_sync_q, sclk_sync_d;
  logic [SS-1:0] cs_sync_q,   cs_sync_d;
  logic [SS-1:0] mosi_sync_q, mosi_sync_d;
  logic          sclk_prev_q, sclk_prev_d;
  logic [WW-1:0] warm_q,      warm_d;
  logic          armed_q,     armed_d;
  logic [1:0]    state_q,     state_d;
  logic [3:0]    cnt_q,       cnt_d;
  logic [7:0]    shift_q,     shift_d;
  logic [7:0]    addr_byte_q, addr_byte_d;
  logic          we_q,        we_d;
  logic          err_q,       err_d;
  logic [7:0]    addr_q,      addr_d;
  logic [7:0]    data_q,      data_d;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise;
  logic       warm_done;
  logic [7:0] frame_bits;
  logic       addr_valid;

  assign sclk_s     = sclk_sync_q[SS-1];
  assign cs_s       = cs_sync_q[SS-1];
  assign mosi_s     = mosi_sync_q[SS-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign warm_done  = (warm_q == WARM_MAX);
  assign frame_bits = {shift_q[6:0], mosi_s};
  assign addr_valid = ({1'b0, addr_byte_q} < NUM_REGS_L);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SS-2:0], bus.sclk};
    cs_sync_d   = {cs_sync_q[SS-2:0],   bus.cs_n};
    mosi_sync_d = {mosi_sync_q[SS-2:0], bus.mosi};
    sclk_prev_d = sclk_s;
  end

  // The cs_n synchronizer comes out of reset at 1 regardless of the pin, so a
  // deasserted cs_n only counts once the pipeline has refilled with real samples.
  // This keeps a frame that was cut by reset from being resumed.
  always_comb begin
    warm_d  = warm_done ? warm_q : warm_q + 1'b1;
    armed_d = armed_q | (warm_done & cs_s);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_byte_d = addr_byte_q;
    we_d        = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (armed_q && !cs_s) begin
          state_d = ADDR;
          cnt_d   = 4'd0;
          shift_d = 8'h00;
        end
      end
      ADDR: begin
        if (cs_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          shift_d = 8'h00;
        end else if (sclk_rise) begin
          shift_d = frame_bits;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            addr_byte_d = frame_bits;
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        if (cs_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          shift_d = 8'h00;
        end else if (sclk_rise) begin
          shift_d = frame_bits;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = WAIT_CS;
            if (addr_valid) begin
              we_d   = 1'b1;
              addr_d = addr_byte_q;
              data_d = frame_bits;
            end else begin
              err_d  = 1'b1;
            end
          end
        end
      end
      WAIT_CS: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      addr_byte_q <= 8'h00;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_byte_q <= addr_byte_d;
      we_q        <= we_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign bus.we       = we_q;
  assign bus.addr_err = err_q;
  assign bus.addr     = addr_q;
  assign bus.data_out = data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_reg_if.sv
// Directed bench for spi_reg_if: table of frames with hand-computed outcomes plus
// hand-written abort and mid-frame reset sequences; writes are scoreboarded.
module tb_spi_reg_if;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  spi_reg_if_if bus ();

  spi_reg_if #(.NUM_REGS(10), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int wide_cnt = 0;
  logic we_prev = 1'b0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         extra;
    int         exp_we;
    int         exp_err;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h expected no write", bus.addr, bus.data_out);
      end else begin
        check("write_pair", {16'h0, bus.addr, bus.data_out}, {16'h0, exp_q.pop_front()});
      end
    end
    if (bus.addr_err === 1'b1) err_cnt++;
    if (bus.we === 1'b1 && bus.addr_err === 1'b1) overlap_cnt++;
    if (bus.we === 1'b1 && we_prev === 1'b1) wide_cnt++;
    we_prev = bus.we;
  end

  // driver: n bits of v, MSB first, sclk = clk/8
  task automatic send_bits(input logic [31:0] v, input int n, input bit raise_cs);
    bus.cs_n = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < n; i++) begin
      bus.mosi = v[n-1-i];
      repeat (4) @(posedge clk);
      bus.sclk = 1'b1;
      repeat (4) @(posedge clk);
      bus.sclk = 1'b0;
    end
    repeat (8) @(posedge clk);
    if (raise_cs) begin
      bus.cs_n = 1'b1;
      repeat (10) @(posedge clk);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] d, input int extra,
                         input int ew, input int ee, input logic [7:0] ea, input logic [7:0] ed);
    vecs[i].a = a; vecs[i].d = d; vecs[i].extra = extra;
    vecs[i].exp_we = ew; vecs[i].exp_err = ee;
    vecs[i].exp_addr = ea; vecs[i].exp_data = ed;
  endtask

  int we0, err0;

  initial begin
    set_vec(0, 8'h03, 8'h40, 0, 1, 0, 8'h03, 8'h40);
    set_vec(1, 8'h0A, 8'hFF, 0, 0, 1, 8'h03, 8'h40);
    set_vec(2, 8'h09, 8'h80, 8, 1, 0, 8'h09, 8'h80);
    for (int k = 0; k < 10; k++)
      set_vec(3 + k, 8'(k), 8'(8'h10 + k), 0, 1, 0, 8'(k), 8'(8'h10 + k));
    set_vec(13, 8'hFF, 8'h00, 0, 0, 1, 8'h09, 8'h19);
    set_vec(14, 8'h00, 8'h5A, 8, 1, 0, 8'h00, 8'h5A);

    rst_n    = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_we", 32'(bus.we), 32'h0);
    check("reset_err", 32'(bus.addr_err), 32'h0);
    check("reset_addr", 32'(bus.addr), 32'h0);
    check("reset_data", 32'(bus.data_out), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    for (int i = 0; i < 15; i++) begin
      we0  = we_cnt;
      err0 = err_cnt;
      if (vecs[i].exp_we != 0) exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_data});
      if (vecs[i].extra != 0)
        send_bits({8'h00, vecs[i].a, vecs[i].d, 8'hA5}, 24, 1'b1);
      else
        send_bits({16'h0, vecs[i].a, vecs[i].d}, 16, 1'b1);
      check($sformatf("vec%0d_we_count", i), 32'(we_cnt - we0), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_err_count", i), 32'(err_cnt - err0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_addr", i), 32'(bus.addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_data", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_idle", i), 32'(dbg_state), 32'h0);
    end

    // abort after 11 bits, then a full frame to the same address
    we0 = we_cnt; err0 = err_cnt;
    send_bits({21'h0, 8'h01, 3'b001}, 11, 1'b1);
    check("abort_we_count", 32'(we_cnt - we0), 32'h0);
    check("abort_err_count", 32'(err_cnt - err0), 32'h0);
    check("abort_addr_hold", 32'(bus.addr), 32'h00);
    check("abort_data_hold", 32'(bus.data_out), 32'h5A);
    exp_q.push_back({8'h01, 8'h20});
    send_bits({16'h0, 8'h01, 8'h20}, 16, 1'b1);
    check("post_abort_we_count", 32'(we_cnt - we0), 32'h1);
    check("post_abort_addr", 32'(bus.addr), 32'h01);
    check("post_abort_data", 32'(bus.data_out), 32'h20);

    // reset in the DATA phase with cs_n still low
    we0 = we_cnt; err0 = err_cnt;
    send_bits({20'h0, 12'h057}, 12, 1'b0);
    check("mid_frame_state", 32'(dbg_state), 32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", 32'(bus.addr), 32'h0);
    check("async_rst_data", 32'(bus.data_out), 32'h0);
    check("async_rst_we", 32'(bus.we), 32'h0);
    check("async_rst_state", 32'(dbg_state), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_bits({16'h0, 8'h05, 8'h77}, 16, 1'b1);
    check("rst_no_resume_we", 32'(we_cnt - we0), 32'h0);
    check("rst_no_resume_err", 32'(err_cnt - err0), 32'h0);
    check("rst_no_resume_addr", 32'(bus.addr), 32'h0);
    exp_q.push_back({8'h05, 8'h77});
    send_bits({16'h0, 8'h05, 8'h77}, 16, 1'b1);
    check("rst_fresh_we", 32'(we_cnt - we0), 32'h1);
    check("rst_fresh_addr", 32'(bus.addr), 32'h05);
    check("rst_fresh_data", 32'(bus.data_out), 32'h77);

    // report
    check("we_err_overlap", 32'(overlap_cnt), 32'h0);
    check("we_pulse_width", 32'(wide_cnt), 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("total_writes", 32'(we_cnt), 32'd15);
    check("total_errors", 32'(err_cnt), 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
